zbuf_writer: RTL and testbench

//  Consumer of the validated point stream (en/x/y/z/p) from the wall-validity stage.

---
 rtl/zbuf_writer.sv | 154 +++++++++++++++
 tb/tb_zbuf_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zbuf_writer.sv
// Depth-tests the validated point stream against a depth RAM and writes nearer point indices to a pixel RAM; clears both on reset/frame_start.
// Three register stages from en to write strobe, one point per cycle, no backpressure (points are dropped and counted instead).
module zbuf_writer #(
   parameter int              SCR_W  = 320,
   parameter int              SCR_H  = 65,
   parameter int              ADDR_W = 15,
   parameter logic signed [9:0] Z_FAR = 10'sh1FF,
   parameter logic [9:0]      BG_P   = 10'h3FF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                en,
   input  logic signed [9:0]   in_x,
   input  logic signed [9:0]   in_y,
   input  logic signed [9:0]   in_z,
   input  logic [9:0]          in_p,
   output logic [ADDR_W-1:0]   zb_raddr,
   input  logic signed [9:0]   zb_rdata,
   output logic                zb_we,
   output logic [ADDR_W-1:0]   zb_waddr,
   output logic signed [9:0]   zb_wdata,
   output logic                pix_we,
   output logic [ADDR_W-1:0]   pix_waddr,
   output logic [9:0]          pix_wdata,
   output logic                busy,
   output logic                clear_done,
   output logic [7:0]          drop_cnt
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(SCR_W * SCR_H - 1);

   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, nxt;

   logic [ADDR_W-1:0]  cnt;
   logic               in_bounds, take, drop, clr_last;
   logic [ADDR_W-1:0]  addr_in;

   logic               a_vld, b_vld, w2_vld;
   logic [ADDR_W-1:0]  a_addr, b_addr, w2_addr;
   logic signed [9:0]  a_z, b_z, w2_z, stored;
   logic [9:0]         a_p, b_p;
   logic               nearer;

   assign in_bounds = !in_x[9] && !in_y[9] &&
                      (int'(in_x[8:0]) < SCR_W) && (int'(in_y[8:0]) < SCR_H);
   assign addr_in   = ADDR_W'(in_y[8:0]) * ADDR_W'(SCR_W) + ADDR_W'(in_x[8:0]);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR;
      else        state <= nxt;
   end

   always_comb begin
      nxt      = state;
      take     = 1'b0;
      drop     = 1'b0;
      clr_last = 1'b0;
      case (state)
         CLEAR: begin
            drop     = en;
            clr_last = !frame_start && (cnt == CNT_LAST);
            if (clr_last) nxt = RUN;
         end
         RUN: begin
            take = en && in_bounds && !frame_start;
            drop = en && (!in_bounds || frame_start);
            if (frame_start) nxt = CLEAR;
         end
         default: nxt = CLEAR;
      endcase
   end

   // The RAM returns old data on a same-cycle read/write, so the two most
   // recent writes are forwarded; the one currently on the bus is newest.
   always_comb begin
      stored = zb_rdata;
      if (zb_we && zb_waddr == b_addr)
         stored = zb_wdata;
      else if (w2_vld && w2_addr == b_addr)
         stored = w2_z;
   end

   assign nearer    = b_vld && (b_z < stored);
   assign zb_raddr  = a_addr;
   assign pix_we    = zb_we;
   assign pix_waddr = zb_waddr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         drop_cnt   <= '0;
         a_vld      <= 1'b0;
         a_addr     <= '0;
         a_z        <= '0;
         a_p        <= '0;
         b_vld      <= 1'b0;
         b_addr     <= '0;
         b_z        <= '0;
         b_p        <= '0;
         w2_vld     <= 1'b0;
         w2_addr    <= '0;
         w2_z       <= '0;
         zb_we      <= 1'b0;
         zb_waddr   <= '0;
         zb_wdata   <= '0;
         pix_wdata  <= '0;
      end else begin
         if (state == CLEAR && !frame_start && cnt != CNT_LAST)
            cnt <= cnt + ADDR_W'(1);
         else
            cnt <= '0;
         busy       <= (nxt == CLEAR);
         clear_done <= clr_last;
         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         a_vld <= take;
         if (take) begin
            a_addr <= addr_in;
            a_z    <= in_z;
            a_p    <= in_p;
         end
         b_vld  <= a_vld && !frame_start;
         b_addr <= a_addr;
         b_z    <= a_z;
         b_p    <= a_p;

         w2_vld  <= zb_we && !frame_start;
         w2_addr <= zb_waddr;
         w2_z    <= zb_wdata;

         // A frame_start cycle issues no write: it restarts the sweep or
         // discards the write that stage B was about to produce.
         if (state == CLEAR) begin
            zb_we     <= !frame_start;
            zb_waddr  <= cnt;
            zb_wdata  <= Z_FAR;
            pix_wdata <= BG_P;
         end else begin
            zb_we <= nearer && !frame_start;
            if (nearer) begin
               zb_waddr  <= b_addr;
               zb_wdata  <= b_z;
               pix_wdata <= b_p;
            end
         end
      end
   end

endmodule

// File: tb/tb_zbuf_writer.sv
// Scoreboard bench for zbuf_writer: stimulus pushes expected writes and checks into queues,
// a negedge monitor pops and compares them against the DUT and a read-old-data RAM model.
module tb_zbuf_writer;

   localparam int SCR_W  = 320;
   localparam int SCR_H  = 65;
   localparam int ADDR_W = 15;
   localparam int NPIX   = SCR_W * SCR_H;

   logic                clk = 1'b0;
   logic                rst_n, frame_start, en;
   logic signed [9:0]   in_x, in_y, in_z;
   logic [9:0]          in_p;
   logic [ADDR_W-1:0]   zb_raddr, zb_waddr, pix_waddr;
   logic signed [9:0]   zb_rdata, zb_wdata;
   logic                zb_we, pix_we, busy, clear_done;
   logic [9:0]          pix_wdata;
   logic [7:0]          drop_cnt;

   always #5 clk = ~clk;

   zbuf_writer #(.SCR_W(SCR_W), .SCR_H(SCR_H), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .en(en),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_p(in_p),
      .zb_raddr(zb_raddr), .zb_rdata(zb_rdata),
      .zb_we(zb_we), .zb_waddr(zb_waddr), .zb_wdata(zb_wdata),
      .pix_we(pix_we), .pix_waddr(pix_waddr), .pix_wdata(pix_wdata),
      .busy(busy), .clear_done(clear_done), .drop_cnt(drop_cnt)
   );

   // Depth RAM model: one-cycle read latency, old data on same-address collision.
   logic [9:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      zb_rdata <= mem[zb_raddr];
      if (zb_we) mem[zb_waddr] <= zb_wdata;
   end

   typedef struct packed {
      logic [14:0] addr;
      logic [9:0]  z;
      logic [9:0]  p;
   } wr_t;

   wr_t   exp_q[$];
   string chk_name_q[$];
   int    chk_act_q[$];
   int    chk_exp_q[$];
   int    ncmp = 0;
   int    nerr = 0;

   wr_t   mon_got, mon_exp;
   string mon_n;
   int    mon_a, mon_x;

   function automatic wr_t mk(input int a, input int z, input int p);
      wr_t w;
      w.addr = a[14:0];
      w.z    = z[9:0];
      w.p    = p[9:0];
      return w;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      chk_name_q.push_back(name);
      chk_act_q.push_back(act);
      chk_exp_q.push_back(exp);
   endtask

   task automatic expect_wr(input int a, input int z, input int p);
      exp_q.push_back(mk(a, z, p));
   endtask

   task automatic expect_clear(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(i, 'h1FF, 'h3FF));
   endtask

   always @(negedge clk) begin
      while (chk_name_q.size() > 0) begin
         mon_n = chk_name_q.pop_front();
         mon_a = chk_act_q.pop_front();
         mon_x = chk_exp_q.pop_front();
         ncmp++;
         if (mon_a != mon_x) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", mon_n, mon_a, mon_x);
         end
      end
      if (zb_we || pix_we) begin
         ncmp++;
         if (zb_we !== pix_we || zb_waddr !== pix_waddr) begin
            nerr++;
            $display("FAIL pix_mirror: zb_we %0d pix_we %0d zb_waddr %0d pix_waddr %0d, expected equal",
                     zb_we, pix_we, zb_waddr, pix_waddr);
         end
      end
      if (zb_we) begin
         ncmp++;
         mon_got.addr = zb_waddr;
         mon_got.z    = zb_wdata;
         mon_got.p    = pix_wdata;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_write: got addr %0d z %0d p %0d, expected no write",
                     mon_got.addr, mon_got.z, mon_got.p);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got != mon_exp) begin
               nerr++;
               $display("FAIL write: got addr %0d z %0d p %0d, expected addr %0d z %0d p %0d",
                        mon_got.addr, mon_got.z, mon_got.p, mon_exp.addr, mon_exp.z, mon_exp.p);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input int z, input int p);
      en   = 1'b1;
      in_x = x[9:0];
      in_y = y[9:0];
      in_z = z[9:0];
      in_p = p[9:0];
      tick();
      en   = 1'b0;
   endtask

   task automatic wait_clear(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 25000 && !seen; i++) begin
         tick();
         if (clear_done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, int'(seen), 1);
      check({tag, "_busy_at_done"}, int'(busy), 0);
      tick();
      check({tag, "_done_pulse"}, int'(clear_done), 0);
      check({tag, "_busy_after"}, int'(busy), 0);
      check({tag, "_pending_writes"}, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; en = 1'b0;
      in_x = '0; in_y = '0; in_z = '0; in_p = '0;
      repeat (3) tick();
      check("rst_zb_we", int'(zb_we), 0);
      check("rst_pix_we", int'(pix_we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_clear_done", int'(clear_done), 0);
      check("rst_drop_cnt", int'(drop_cnt), 0);
      check("rst_raddr", int'(zb_raddr), 0);

      // 1: power-up clear of every pixel
      expect_clear(NPIX);
      rst_n = 1'b1;
      tick();
      check("clr1_busy_first", int'(busy), 1);
      wait_clear("clr1");

      // 2: single point, latency of three edges after the sampling edge
      expect_wr(645, 100, 7);
      send(5, 2, 100, 7);
      check("t2_raddr", int'(zb_raddr), 645);
      check("t2_we_e1", int'(zb_we), 0);
      tick();
      check("t2_we_e2", int'(zb_we), 0);
      tick();
      check("t2_we_e3", int'(zb_we), 1);
      tick();
      check("t2_we_e4", int'(zb_we), 0);

      // 3: back-to-back same pixel, forward from the write on the bus
      expect_wr(3, 50, 1);
      expect_wr(3, 20, 2);
      send(3, 0, 50, 1);
      send(3, 0, 20, 2);
      send(3, 0, 30, 3);
      repeat (5) tick();
      check("t3_final_depth", int'(mem[3]), 20);

      // 4: gap-1 same pixel, equal depth loses, nearer wins
      expect_wr(2889, 40, 4);
      expect_wr(2889, 39, 6);
      send(9, 9, 40, 4);
      tick();
      send(9, 9, 40, 5);
      send(9, 9, 39, 6);
      repeat (5) tick();
      check("t4_final_depth", int'(mem[2889]), 39);

      // 5: out-of-range drops, raddr hold, far-corner pixel accepted
      send(-1, 0, 1, 1);
      send(320, 0, 1, 1);
      send(0, 65, 1, 1);
      check("t5_raddr_hold", int'(zb_raddr), 2889);
      expect_wr(20799, 5, 9);
      send(319, 64, 5, 9);
      check("t5_raddr_corner", int'(zb_raddr), 20799);
      repeat (4) tick();
      check("t5_drop_cnt", int'(drop_cnt), 3);

      // 6: frame_start with two points in flight plus one presented, then restart at cnt=100
      send(10, 10, 1, 1);
      send(11, 10, 1, 2);
      expect_clear(100);
      expect_clear(NPIX);
      frame_start = 1'b1;
      en = 1'b1; in_x = 10'sd12; in_y = 10'sd10; in_z = 10'sd1; in_p = 10'd3;
      tick();
      frame_start = 1'b0;
      en = 1'b0;
      check("t6_we_at_flush", int'(zb_we), 0);
      check("t6_busy", int'(busy), 1);
      check("t6_drop_cnt", int'(drop_cnt), 4);
      repeat (100) tick();
      check("t6_addr_before_restart", int'(zb_waddr), 99);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("t6_we_at_restart", int'(zb_we), 0);
      tick();
      check("t6_restart_addr", int'(zb_waddr), 0);
      for (int i = 0; i < 300; i++) send(1, 1, 1, 1);
      check("t6_drop_sat", int'(drop_cnt), 255);
      wait_clear("clr2");

      // freshly cleared buffer accepts the same point again
      expect_wr(645, 100, 7);
      send(5, 2, 100, 7);
      repeat (5) tick();
      check("end_pending_writes", exp_q.size(), 0);

      repeat (2) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
